detection_collector: RTL and testbench

DETECTION_COLLECTOR -- requirements
Module: detection_collector

---
 rtl/detection_collector.sv | 139 +++++++++++++
 tb/tb_detection_collector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/detection_collector.sv
// Detection collector: buffers passing classifier windows per frame in a
// first-word-fall-through FIFO and hands them to the OS side with valid/ready.
module detection_collector #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int FIFO_DEPTH    = 16,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     clk_os,
  input  logic                     reset_os,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     cand_valid,
  input  logic                     candidate,
  input  logic [DATA_WIDTH_12-1:0] scale_xcoord,
  input  logic [DATA_WIDTH_12-1:0] scale_ycoord,
  input  logic                     det_ready,
  output logic                     det_valid,
  output logic [DATA_WIDTH_12-1:0] det_xcoord,
  output logic [DATA_WIDTH_12-1:0] det_ycoord,
  output logic [COUNT_WIDTH-1:0]   det_count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 2 * DATA_WIDTH_12;
  localparam logic [OCC_W-1:0]       FULL_OCC  = OCC_W'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_next;
  logic [COUNT_WIDTH-1:0] r_det_count;
  logic             r_overflow;

  logic             w_cand;
  logic             w_empty;
  logic             w_full;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [PTR_W-1:0] w_wr_addr;
  logic [ENT_W-1:0] w_head;

  assign w_cand  = cand_valid & candidate;
  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == FULL_OCC);

  // A frame_start flushes the FIFO this cycle, so no handshake can retire an
  // entry and a coincident candidate always lands in the emptied buffer.
  assign w_pop      = ~w_empty & det_ready & ~frame_start;
  assign w_push_req = w_cand & (frame_start | (r_state == S_COLLECT));
  assign w_push     = frame_start ? w_cand : (w_push_req & (~w_full | w_pop));
  assign w_drop     = ~frame_start & w_push_req & w_full & ~w_pop;
  assign w_wr_addr  = frame_start ? '0 : r_wr_ptr;

  always_comb begin
    w_occ_next = r_occ;
    if (frame_start) begin
      w_occ_next = w_push ? OCC_W'(1) : '0;
    end else if (w_push && !w_pop) begin
      w_occ_next = r_occ + 1'b1;
    end else if (!w_push && w_pop) begin
      w_occ_next = r_occ - 1'b1;
    end
  end

  // DRAIN closes on the cycle that retires the last entry, so frame_done
  // follows the final pop by exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    if (frame_start) begin
      w_state_next = S_COLLECT;
    end else begin
      case (r_state)
        S_IDLE:    w_state_next = S_IDLE;
        S_COLLECT: if (frame_end) w_state_next = S_DRAIN;
        S_DRAIN:   if (w_occ_next == '0) w_state_next = S_DONE;
        S_DONE:    w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_os) begin
    if (!reset_os) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_det_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_occ   <= w_occ_next;
      if (frame_start) begin
        r_rd_ptr    <= '0;
        r_wr_ptr    <= w_push ? PTR_W'(1) : '0;
        r_det_count <= w_push ? COUNT_WIDTH'(1) : '0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && (r_det_count != COUNT_MAX)) r_det_count <= r_det_count + 1'b1;
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_os) begin
    if (w_push) r_mem[w_wr_addr] <= {scale_xcoord, scale_ycoord};
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign det_valid  = ~w_empty;
  assign det_xcoord = w_empty ? '0 : w_head[ENT_W-1:DATA_WIDTH_12];
  assign det_ycoord = w_empty ? '0 : w_head[DATA_WIDTH_12-1:0];
  assign det_count  = r_det_count;
  assign overflow   = r_overflow;
  assign busy       = (r_state == S_COLLECT) || (r_state == S_DRAIN);
  assign frame_done = (r_state == S_DONE);

endmodule

// File: tb/tb_detection_collector.sv
// Scoreboard bench for detection_collector: directed frame scenarios followed
// by randomized traffic, checked against a queue-based reference model.
module tb_detection_collector;
  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk_os = 1'b0;
  logic          reset_os = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          cand_valid = 1'b0;
  logic          candidate = 1'b0;
  logic [DW-1:0] scale_xcoord = '0;
  logic [DW-1:0] scale_ycoord = '0;
  logic          det_ready = 1'b0;
  logic          det_valid;
  logic [DW-1:0] det_xcoord;
  logic [DW-1:0] det_ycoord;
  logic [CW-1:0] det_count;
  logic          overflow;
  logic          busy;
  logic          frame_done;

  detection_collector #(
    .DATA_WIDTH_12(DW),
    .FIFO_DEPTH   (DEPTH),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk_os      (clk_os),
    .reset_os    (reset_os),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .cand_valid  (cand_valid),
    .candidate   (candidate),
    .scale_xcoord(scale_xcoord),
    .scale_ycoord(scale_ycoord),
    .det_ready   (det_ready),
    .det_valid   (det_valid),
    .det_xcoord  (det_xcoord),
    .det_ycoord  (det_ycoord),
    .det_count   (det_count),
    .overflow    (overflow),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk_os = ~clk_os;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done.
  logic [2*DW-1:0] exp_q[$];
  int  m_occ = 0;
  int  m_phase = 0;
  int  m_count = 0;
  bit  m_ovf = 1'b0;
  bit  m_pop;
  bit  m_push;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_os) begin
    if (!reset_os) begin
      exp_q.delete();
      m_occ = 0; m_phase = 0; m_count = 0; m_ovf = 1'b0;
    end else if (frame_start) begin
      exp_q.delete();
      m_occ = 0; m_count = 0; m_ovf = 1'b0; m_phase = 1;
      if (cand_valid && candidate) begin
        exp_q.push_back({scale_xcoord, scale_ycoord});
        m_occ = 1; m_count = 1;
      end
    end else begin
      m_pop  = (m_occ > 0) && det_ready;
      m_push = 1'b0;
      if (cand_valid && candidate && m_phase == 1) begin
        if (m_occ < DEPTH || m_pop) begin
          m_push = 1'b1;
          exp_q.push_back({scale_xcoord, scale_ycoord});
          if (m_count < CMAX) m_count++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_occ = m_occ + int'(m_push) - int'(m_pop);
      case (m_phase)
        1: if (frame_end) m_phase = 2;
        2: if (m_occ == 0) m_phase = 3;
        3: m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // Monitor: compares the presented head and pops it on each handshake.
  always @(negedge clk_os) begin
    if (mon_en) begin
      chk("det_valid", 32'(det_valid), 32'(m_occ != 0));
      if (det_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_det", 32'(det_valid), 32'd0);
        end else begin
          chk("det_xcoord", 32'(det_xcoord), 32'(exp_q[0][2*DW-1:DW]));
          chk("det_ycoord", 32'(det_ycoord), 32'(exp_q[0][DW-1:0]));
          if (det_ready) begin
            $display("deliver x=%0d y=%0d count=%0d t=%0t", det_xcoord, det_ycoord, det_count, $time);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("empty_x_zero", 32'(det_xcoord), 32'd0);
        chk("empty_y_zero", 32'(det_ycoord), 32'd0);
      end
      chk("det_count", 32'(det_count), 32'(m_count));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      chk("frame_done", 32'(frame_done), 32'(m_phase == 3));
    end
  end

  task automatic drive(input bit fs, input bit fe, input bit cv, input bit cd,
                       input int x, input int y, input bit rdy);
    frame_start  = fs;
    frame_end    = fe;
    cand_valid   = cv;
    candidate    = cd;
    scale_xcoord = x[DW-1:0];
    scale_ycoord = y[DW-1:0];
    det_ready    = rdy;
    @(posedge clk_os);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, rdy);
  endtask

  int done_cnt;

  initial begin
    reset_os = 1'b0;
    repeat (2) @(posedge clk_os);
    #1;
    mon_en = 1'b1;
    chk("rst_valid", 32'(det_valid), 32'd0);
    chk("rst_count", 32'(det_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_os = 1'b1;
    idle(2, 1);

    // Basic delivery
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 1, 10, 20, 1);
    chk("s1_valid_latency", 32'(det_valid), 32'd1);
    chk("s1_first_x", 32'(det_xcoord), 32'd10);
    drive(0, 0, 1, 1, 30, 40, 1);
    drive(0, 1, 0, 0, 0, 0, 1);
    chk("s1_count", 32'(det_count), 32'd2);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      done_cnt += int'(frame_done);
    end
    chk("s1_done_pulses", 32'(done_cnt), 32'd1);

    // Overflow with the consumer stalled
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 1, 1, i, i + 100, 0);
      if (i == 15) chk("s2_no_ovf_at_16", 32'(overflow), 32'd0);
    end
    chk("s2_count", 32'(det_count), 32'd16);
    chk("s2_overflow", 32'(overflow), 32'd1);
    drive(0, 1, 0, 0, 0, 0, 1);
    idle(20, 1);
    chk("s2_drained", 32'(det_valid), 32'd0);

    // Push and pop together while full
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 1, 1, i, i, 0);
    drive(0, 0, 1, 1, 99, 99, 1);
    chk("s3_count", 32'(det_count), 32'd17);
    chk("s3_overflow", 32'(overflow), 32'd0);
    drive(0, 1, 0, 0, 0, 0, 1);
    idle(20, 1);

    // Backpressure during drain, late candidates ignored
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 200 + i, 300 + i, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      drive(0, 0, 1, 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), (i % 2) == 0);
    chk("s4_count", 32'(det_count), 32'd3);
    idle(4, 1);

    // frame_start with a coincident candidate, then reset mid-frame
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 50 + i, 60 + i, 0);
    drive(1, 0, 1, 1, 7, 8, 0);
    chk("s5_count", 32'(det_count), 32'd1);
    chk("s5_overflow", 32'(overflow), 32'd0);
    chk("s5_x", 32'(det_xcoord), 32'd7);
    chk("s5_y", 32'(det_ycoord), 32'd8);
    idle(2, 0);
    reset_os = 1'b0;
    drive(1, 0, 1, 1, 5, 5, 1);
    reset_os = 1'b1;
    chk("s5_rst_valid", 32'(det_valid), 32'd0);
    chk("s5_rst_x", 32'(det_xcoord), 32'd0);
    chk("s5_rst_y", 32'(det_ycoord), 32'd0);
    chk("s5_rst_count", 32'(det_count), 32'd0);
    chk("s5_rst_ovf", 32'(overflow), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_done", 32'(frame_done), 32'd0);
    drive(0, 0, 1, 1, 9, 9, 1);
    chk("s5_idle_ignored", 32'(det_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_os = ($urandom_range(0, 499) != 0);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
            $urandom_range(0, 2) != 0);
    end
    reset_os = 1'b1;
    idle(30, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
